alu_hw_generator: RTL and testbench

- Hardware transaction generator for the hardware-accelerated (sw/hw) ALU verification framework.
- Produces pseudo-random ALU transactions (OP, MOVI, REG_A, MEM, IMM) on a valid/ready stream that feeds the ALU driver side.
- Inserts weighted random inter-transaction delays.
- Fully reproducible from a 32-bit seed; generalises DATA_WIDTH beyond 8.

---
 rtl/alu_hw_gen_pkg.sv | 26 ++
 rtl/alu_lfsr32.sv | 23 ++
 rtl/alu_hw_generator.sv | 129 ++++++++++++
 tb/tb_alu_hw_generator.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_hw_gen_pkg.sv
// Shared types, constants and sizing helpers for the ALU hardware transaction generator.
package alu_hw_gen_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_GEN,
    S_SEND,
    S_DELAY,
    S_DONE
  } state_t;

  localparam logic [31:0] LFSR_MASK = 32'h8020_0003;
  localparam int OP_W   = 4;
  localparam int MOVI_W = 2;

  // Random bits consumed per transaction: IMM, MEM, REG_A, MOVI, OP.
  function automatic int calc_f(input int dw);
    return 3 * dw + MOVI_W + OP_W;
  endfunction

  // LFSR words needed to cover one transaction.
  function automatic int calc_k(input int dw);
    return (calc_f(dw) + 31) / 32;
  endfunction

endpackage

// File: rtl/alu_lfsr32.sv
// 32-bit Galois LFSR; a zero seed is replaced by 1 so the register never locks up.
module alu_lfsr32
  import alu_hw_gen_pkg::*;
(
  input  logic        CLK,
  input  logic        RESET,
  input  logic        load,
  input  logic [31:0] load_val,
  input  logic        step,
  output logic [31:0] state_next
);

  logic [31:0] s;

  assign state_next = (s >> 1) ^ (s[0] ? LFSR_MASK : 32'h0);

  always_ff @(posedge CLK) begin
    if (RESET)     s <= 32'h1;
    else if (load) s <= (load_val == 32'h0) ? 32'h1 : load_val;
    else if (step) s <= state_next;
  end

endmodule

// File: rtl/alu_hw_generator.sv
// Seeded pseudo-random ALU transaction generator with weighted inter-transaction delays.
// Optional statistics outputs are enabled with `define ALU_HW_GEN_STATS_EN.
module alu_hw_generator
  import alu_hw_gen_pkg::*;
#(
  parameter int DATA_WIDTH     = 8,
  parameter int BT_DELAY_EN_WT = 1,
  parameter int BT_DELAY_DI_WT = 10,
  parameter int BT_DELAY_LOW   = 1,
  parameter int BT_DELAY_HIGH  = 10
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  START,
  input  logic [31:0]           SEED,
  input  logic [31:0]           TRANS_COUNT,
  output logic                  BUSY,
  output logic                  DONE,
  output logic                  OUT_VLD,
  input  logic                  OUT_RDY,
  output logic [OP_W-1:0]       OUT_OP,
  output logic [MOVI_W-1:0]     OUT_MOVI,
  output logic [DATA_WIDTH-1:0] OUT_REG_A,
  output logic [DATA_WIDTH-1:0] OUT_MEM,
  output logic [DATA_WIDTH-1:0] OUT_IMM
`ifdef ALU_HW_GEN_STATS_EN
  ,
  output logic [15:0]           STAT_DELAYS,
  output logic [31:0]           STAT_DELAY_CYCLES
`endif
);

  localparam int F      = calc_f(DATA_WIDTH);
  localparam int K      = calc_k(DATA_WIDTH);
  localparam int GW     = (K > 1) ? $clog2(K) : 1;
  localparam int WSUM   = BT_DELAY_EN_WT + BT_DELAY_DI_WT;
  localparam int DRANGE = BT_DELAY_HIGH - BT_DELAY_LOW + 1;

  state_t          state, nxt;
  logic [31:0]     remaining;
  logic [GW-1:0]   gen_cnt;
  logic [7:0]      dly_cnt;
  logic [F-1:0]    fill;
  logic [31:0]     r;
  logic [31:0]     wt_mod;
  logic [15:0]     dly_mod;
  logic [7:0]      dly_val;
  logic            start_acc, hs, take_delay, enter_delay;

  assign start_acc = (state == S_IDLE) && START;
  assign hs        = (state == S_SEND) && OUT_RDY;

  alu_lfsr32 u_lfsr (
    .CLK        (CLK),
    .RESET      (RESET),
    .load       (start_acc),
    .load_val   (SEED),
    .step       ((state == S_GEN) || hs),
    .state_next (r)
  );

  // Delay decision uses the LFSR value produced by the handshake step.
  assign wt_mod      = r % 32'(WSUM);
  assign take_delay  = wt_mod < 32'(BT_DELAY_EN_WT);
  assign dly_mod     = r[31:16] % 16'(DRANGE);
  assign dly_val     = 8'(BT_DELAY_LOW) + dly_mod[7:0];
  assign enter_delay = hs && (nxt == S_DELAY);

  always_comb begin
    nxt = state;
    case (state)
      S_IDLE:  if (START) nxt = (TRANS_COUNT == 32'h0) ? S_DONE : S_GEN;
      S_GEN:   if (gen_cnt == GW'(K - 1)) nxt = S_SEND;
      S_SEND: begin
        if (OUT_RDY) begin
          if (remaining == 32'd1) nxt = S_DONE;
          else if (take_delay)    nxt = S_DELAY;
          else                    nxt = S_GEN;
        end
      end
      S_DELAY: if (dly_cnt == 8'd1) nxt = S_GEN;
      S_DONE:  nxt = S_IDLE;
      default: nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state     <= S_IDLE;
      remaining <= 32'h0;
      gen_cnt   <= '0;
      dly_cnt   <= 8'h0;
      fill      <= '0;
    end else begin
      state   <= nxt;
      gen_cnt <= (state == S_GEN) ? gen_cnt + GW'(1) : '0;
      if (start_acc)     remaining <= TRANS_COUNT;
      else if (hs)       remaining <= remaining - 32'd1;
      // Newest word lands in the low bits; older words shift up and fall off past F.
      if (state == S_GEN) fill <= F'({fill, r});
      if (enter_delay)             dly_cnt <= dly_val;
      else if (state == S_DELAY)   dly_cnt <= dly_cnt - 8'd1;
    end
  end

`ifdef ALU_HW_GEN_STATS_EN
  always_ff @(posedge CLK) begin
    if (RESET || start_acc) begin
      STAT_DELAYS       <= 16'h0;
      STAT_DELAY_CYCLES <= 32'h0;
    end else begin
      if (enter_delay && (STAT_DELAYS != 16'hFFFF))
        STAT_DELAYS <= STAT_DELAYS + 16'd1;
      if ((state == S_DELAY) && (STAT_DELAY_CYCLES != 32'hFFFF_FFFF))
        STAT_DELAY_CYCLES <= STAT_DELAY_CYCLES + 32'd1;
    end
  end
`endif

  assign BUSY      = (state == S_GEN) || (state == S_SEND) || (state == S_DELAY);
  assign DONE      = (state == S_DONE);
  assign OUT_VLD   = (state == S_SEND);
  assign OUT_IMM   = fill[DATA_WIDTH-1:0];
  assign OUT_MEM   = fill[2*DATA_WIDTH-1:DATA_WIDTH];
  assign OUT_REG_A = fill[3*DATA_WIDTH-1:2*DATA_WIDTH];
  assign OUT_MOVI  = fill[3*DATA_WIDTH+MOVI_W-1:3*DATA_WIDTH];
  assign OUT_OP    = fill[F-1:3*DATA_WIDTH+MOVI_W];

endmodule

// File: tb/tb_alu_hw_generator.sv
// Bench for alu_hw_generator: three configurations checked against a transaction-level model.
module tb_alu_hw_generator;

  logic        CLK, RESET, START, RDY;
  logic [31:0] SEED, TRANS_COUNT;

  logic       busy0, done0, vld0, busy1, done1, vld1, busy2, done2, vld2;
  logic [3:0] op0, op1, op2;
  logic [1:0] movi0, movi1, movi2;
  logic [7:0] rega0, mem0, imm0, rega1, mem1, imm1;
  logic [15:0] rega2, mem2, imm2;

  // config table: DATA_WIDTH, EN_WT, DI_WT, LOW, HIGH per instance
  int c_dw[3] = '{8, 8, 16};
  int c_en[3] = '{0, 1, 3};
  int c_di[3] = '{1, 0, 5};
  int c_lo[3] = '{1, 3, 2};
  int c_hi[3] = '{10, 3, 9};

  alu_hw_generator #(.DATA_WIDTH(8), .BT_DELAY_EN_WT(0), .BT_DELAY_DI_WT(1),
                     .BT_DELAY_LOW(1), .BT_DELAY_HIGH(10)) u0 (
    .CLK(CLK), .RESET(RESET), .START(START), .SEED(SEED), .TRANS_COUNT(TRANS_COUNT),
    .BUSY(busy0), .DONE(done0), .OUT_VLD(vld0), .OUT_RDY(RDY), .OUT_OP(op0),
    .OUT_MOVI(movi0), .OUT_REG_A(rega0), .OUT_MEM(mem0), .OUT_IMM(imm0));

  alu_hw_generator #(.DATA_WIDTH(8), .BT_DELAY_EN_WT(1), .BT_DELAY_DI_WT(0),
                     .BT_DELAY_LOW(3), .BT_DELAY_HIGH(3)) u1 (
    .CLK(CLK), .RESET(RESET), .START(START), .SEED(SEED), .TRANS_COUNT(TRANS_COUNT),
    .BUSY(busy1), .DONE(done1), .OUT_VLD(vld1), .OUT_RDY(RDY), .OUT_OP(op1),
    .OUT_MOVI(movi1), .OUT_REG_A(rega1), .OUT_MEM(mem1), .OUT_IMM(imm1));

  alu_hw_generator #(.DATA_WIDTH(16), .BT_DELAY_EN_WT(3), .BT_DELAY_DI_WT(5),
                     .BT_DELAY_LOW(2), .BT_DELAY_HIGH(9)) u2 (
    .CLK(CLK), .RESET(RESET), .START(START), .SEED(SEED), .TRANS_COUNT(TRANS_COUNT),
    .BUSY(busy2), .DONE(done2), .OUT_VLD(vld2), .OUT_RDY(RDY), .OUT_OP(op2),
    .OUT_MOVI(movi2), .OUT_REG_A(rega2), .OUT_MEM(mem2), .OUT_IMM(imm2));

  int sel;
  logic m_busy, m_done, m_vld;
  logic [3:0] m_op;
  logic [1:0] m_movi;
  logic [15:0] m_rega, m_mem, m_imm;

  always_comb begin
    m_busy = busy0; m_done = done0; m_vld = vld0; m_op = op0; m_movi = movi0;
    m_rega = {8'h0, rega0}; m_mem = {8'h0, mem0}; m_imm = {8'h0, imm0};
    if (sel == 1) begin
      m_busy = busy1; m_done = done1; m_vld = vld1; m_op = op1; m_movi = movi1;
      m_rega = {8'h0, rega1}; m_mem = {8'h0, mem1}; m_imm = {8'h0, imm1};
    end else if (sel == 2) begin
      m_busy = busy2; m_done = done2; m_vld = vld2; m_op = op2; m_movi = movi2;
      m_rega = rega2; m_mem = mem2; m_imm = imm2;
    end
  end

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  int total = 0;
  int bad = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] lstep(input logic [31:0] s);
    return (s >> 1) ^ (s[0] ? 32'h8020_0003 : 32'h0);
  endfunction

  // expected per-transaction fields and idle cycles before each OUT_VLD
  logic [63:0] e_imm[$], e_mem[$], e_rega[$], e_movi[$], e_op[$];
  int e_gap[$];
  logic [15:0] first_imm, first_mem, first_rega;
  logic [3:0]  first_op;
  logic [1:0]  first_movi;
  int first_lat;

  task automatic run(input int s, input logic [31:0] seed, input int count,
                     input int mode, input bit poke);
    logic [31:0] st;
    logic [63:0] fill, msk;
    int dw, k, idx, gap, vcyc, cyc;
    bit fin, r;
    dw = c_dw[s];
    k = (3 * dw + 6 + 31) / 32;
    msk = (64'h1 << dw) - 64'h1;
    e_imm.delete(); e_mem.delete(); e_rega.delete(); e_movi.delete(); e_op.delete();
    e_gap.delete();
    st = (seed == 32'h0) ? 32'h1 : seed;
    for (int i = 0; i < count; i++) begin
      fill = 64'h0;
      for (int j = 0; j < k; j++) begin
        st = lstep(st);
        fill = (fill << 32) | {32'h0, st};
      end
      e_imm.push_back(fill & msk);
      e_mem.push_back((fill >> dw) & msk);
      e_rega.push_back((fill >> (2 * dw)) & msk);
      e_movi.push_back((fill >> (3 * dw)) & 64'h3);
      e_op.push_back((fill >> (3 * dw + 2)) & 64'hF);
      if (i == 0) e_gap.push_back(k);
      st = lstep(st);
      if (i < count - 1) begin
        if (int'(st % (c_en[s] + c_di[s])) < c_en[s])
          e_gap.push_back(c_lo[s] + int'(st[31:16] % (c_hi[s] - c_lo[s] + 1)) + k);
        else
          e_gap.push_back(k);
      end
    end

    sel = s;
    SEED = seed; TRANS_COUNT = count; START = 1'b1; RDY = 1'b0;
    idx = 0; gap = 0; vcyc = 0; cyc = 0; fin = 0;
    while (!fin && cyc < 5000) begin
      @(negedge CLK);
      cyc++;
      START = 1'b0;
      if (idx == count) begin
        chk("done_pulse", m_done, 1);
        chk("busy_at_done", m_busy, 0);
        chk("vld_at_done", m_vld, 0);
        fin = 1;
      end else begin
        chk("busy_run", m_busy, 1);
        chk("done_run", m_done, 0);
        r = ($urandom % 2) == 1;
        if (m_vld) begin
          if (vcyc == 0) begin
            chk("gap", gap, e_gap[idx]);
            if (idx == 0) begin
              first_lat = cyc; first_imm = m_imm; first_mem = m_mem;
              first_rega = m_rega; first_movi = m_movi; first_op = m_op;
            end
          end
          chk("imm", m_imm, e_imm[idx]);
          chk("mem", m_mem, e_mem[idx]);
          chk("reg_a", m_rega, e_rega[idx]);
          chk("movi", m_movi, e_movi[idx]);
          chk("op", m_op, e_op[idx]);
          vcyc++;
          if (mode == 0) r = 1;
          else if (mode == 2) r = (vcyc > 5);
          if (r) begin
            if (mode == 2) chk("stall_len", vcyc, 6);
            idx++; gap = 0; vcyc = 0;
          end
        end else begin
          gap++;
        end
        RDY = r;
        if (poke && cyc == 3 && m_busy) begin
          START = 1'b1; SEED = ~seed; TRANS_COUNT = 7;
        end
      end
    end
    if (!fin) chk("timeout", 0, 1);
    RDY = 1'b0;
    @(negedge CLK);
    chk("done_cleared", m_done, 0);
    chk("idle_busy", m_busy, 0);
  endtask

  int w;
  logic [15:0] pre_imm, pre_mem, pre_rega;

  initial begin
    sel = 0; RESET = 1'b1; START = 1'b0; SEED = 32'h0; TRANS_COUNT = 32'h0; RDY = 1'b0;
    first_lat = 0;
    repeat (3) @(negedge CLK);
    for (int s = 0; s < 3; s++) begin
      sel = s;
      #1;
      chk("rst_vld", m_vld, 0);
      chk("rst_busy", m_busy, 0);
      chk("rst_done", m_done, 0);
      chk("rst_fields", {m_op, m_movi, m_rega, m_mem, m_imm}, 0);
    end
    RESET = 1'b0;
    @(negedge CLK);

    // first transaction, latency, spacing and DONE timing
    run(0, 32'h1, 4, 0, 0);
    chk("first_lat", first_lat, 2);
    chk("first_imm", first_imm, 16'h03);
    chk("first_mem", first_mem, 16'h00);
    chk("first_rega", first_rega, 16'h20);
    chk("first_movi", first_movi, 0);
    chk("first_op", first_op, 0);

    // zero seed behaves as seed 1
    run(0, 32'h0, 4, 0, 0);
    chk("seed0_imm", first_imm, 16'h03);
    chk("seed0_rega", first_rega, 16'h20);

    run(0, 32'h1, 0, 0, 0);
    run(1, 32'h1234_5678, 6, 0, 0);
    run(0, 32'hDEAD_BEEF, 5, 2, 0);
    run(1, $urandom, 5, 1, 1);
    for (int i = 0; i < 4; i++) run(2, $urandom, $urandom_range(2, 12), 1, 1);
    run(2, $urandom, 4, 2, 0);

    // reset in the middle of a run, then replay the same seed
    sel = 0; SEED = 32'hACE1; TRANS_COUNT = 50; START = 1'b1; RDY = 1'b0;
    @(negedge CLK);
    START = 1'b0;
    w = 0;
    while (!m_vld && w < 20) begin
      @(negedge CLK);
      w++;
    end
    chk("mid_vld", m_vld, 1);
    pre_imm = m_imm; pre_mem = m_mem; pre_rega = m_rega;
    RESET = 1'b1;
    @(negedge CLK);
    chk("mid_rst_vld", m_vld, 0);
    chk("mid_rst_busy", m_busy, 0);
    chk("mid_rst_done", m_done, 0);
    repeat (2) begin
      @(negedge CLK);
      chk("mid_rst_nodone", m_done, 0);
    end
    RESET = 1'b0;
    @(negedge CLK);
    chk("post_rst_done", m_done, 0);
    chk("post_rst_busy", m_busy, 0);
    run(0, 32'hACE1, 5, 0, 0);
    chk("replay_imm", first_imm, pre_imm);
    chk("replay_mem", first_mem, pre_mem);
    chk("replay_rega", first_rega, pre_rega);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
